// File: rtl/debug_frame_tx.sv
// Debug readout transmitter: snapshots parallel debug words on a trigger and
// streams them as a header / count / big-endian data / XOR-checksum byte frame.
module debug_frame_tx #(
  parameter int         NUM_WORDS = 3,
  parameter logic [7:0] HEADER    = 8'hA5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       trig_i,
  input  logic [NUM_WORDS-1:0][31:0] dbg_words_i,
  output logic [7:0]                 tx_data_o,
  output logic                       tx_vld_o,
  input  logic                       tx_rdy_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [15:0]                frame_cnt_o
);

  localparam logic [7:0] LAST_IDX = 8'(4 * NUM_WORDS - 1);
  localparam logic [7:0] WORD_CNT = 8'(NUM_WORDS);

  typedef enum logic [2:0] {IDLE, HDR, CNT, DATA, CSUM} state_t;

  state_t                      state_reg;
  logic                        pending_reg;
  logic [NUM_WORDS-1:0][31:0]  shadow_reg;
  logic [7:0]                  csum_reg;
  logic [7:0]                  idx_reg;
  logic [7:0]                  tx_data_reg;
  logic                        tx_vld_reg;
  logic                        busy_reg;
  logic                        done_reg;
  logic [15:0]                 frame_cnt_reg;

  logic                        handshake;
  logic [7:0]                  idx_next;
  logic [7:0]                  csum_next;
  logic [7:0]                  byte_next;
  logic [5:0]                  word_sel;
  logic [NUM_WORDS-1:0][31:0]  word_masked;
  logic [31:0]                 word_next;

  assign handshake = tx_vld_reg & tx_rdy_i;
  assign csum_next = csum_reg ^ tx_data_reg;
  // Index of the byte to present after this handshake; CNT hands off to byte 0.
  assign idx_next  = (state_reg == DATA) ? idx_reg + 8'd1 : 8'd0;
  assign word_sel  = idx_next[7:2];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_WORDS; gi++) begin : g_word_mux
      assign word_masked[gi] = (word_sel == 6'(gi)) ? shadow_reg[gi] : '0;
    end
  endgenerate

  always_comb begin
    word_next = '0;
    for (int k = 0; k < NUM_WORDS; k++) begin
      word_next = word_next | word_masked[k];
    end
  end

  always_comb begin
    byte_next = '0;
    case (idx_next[1:0])
      2'd0:    byte_next = word_next[31:24];
      2'd1:    byte_next = word_next[23:16];
      2'd2:    byte_next = word_next[15:8];
      default: byte_next = word_next[7:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      pending_reg   <= 1'b0;
      shadow_reg    <= '0;
      csum_reg      <= '0;
      idx_reg       <= '0;
      tx_data_reg   <= '0;
      tx_vld_reg    <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      frame_cnt_reg <= '0;
    end else begin
      done_reg <= 1'b0;
      if (trig_i && state_reg != IDLE) begin
        pending_reg <= 1'b1;
      end
      case (state_reg)
        IDLE: begin
          csum_reg <= '0;
          if (trig_i || pending_reg) begin
            state_reg   <= HDR;
            pending_reg <= 1'b0;
            shadow_reg  <= dbg_words_i;
            csum_reg    <= HEADER;
            tx_data_reg <= HEADER;
            tx_vld_reg  <= 1'b1;
            busy_reg    <= 1'b1;
          end
        end
        HDR: begin
          if (handshake) begin
            state_reg   <= CNT;
            tx_data_reg <= WORD_CNT;
          end
        end
        CNT: begin
          if (handshake) begin
            state_reg   <= DATA;
            csum_reg    <= csum_next;
            idx_reg     <= '0;
            tx_data_reg <= byte_next;
          end
        end
        DATA: begin
          if (handshake) begin
            csum_reg <= csum_next;
            idx_reg  <= idx_next;
            if (idx_reg == LAST_IDX) begin
              state_reg   <= CSUM;
              tx_data_reg <= csum_next;
            end else begin
              tx_data_reg <= byte_next;
            end
          end
        end
        CSUM: begin
          if (handshake) begin
            state_reg     <= IDLE;
            tx_data_reg   <= '0;
            tx_vld_reg    <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b1;
            frame_cnt_reg <= frame_cnt_reg + 16'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign tx_data_o   = tx_data_reg;
  assign tx_vld_o    = tx_vld_reg;
  assign busy_o      = busy_reg;
  assign done_o      = done_reg;
  assign frame_cnt_o = frame_cnt_reg;

endmodule

// File: tb/tb_debug_frame_tx.sv
// Directed bench for debug_frame_tx: frame contents, backpressure, snapshot,
// trigger while busy, reset mid-frame and frame counter wrap.
module tb_debug_frame_tx;

  localparam int NW        = 3;
  localparam int FRAME_LEN = 3 + 4 * NW;

  logic              clk    = 1'b0;
  logic              rst_n  = 1'b0;
  logic              trig   = 1'b0;
  logic              tx_rdy = 1'b0;
  logic [NW-1:0][31:0] dbg_words;
  logic [7:0]        tx_data;
  logic              tx_vld;
  logic              busy;
  logic              done;
  logic [15:0]       frame_cnt;

  int         total = 0;
  int         bad   = 0;
  int         nrecv;
  logic [7:0] exp_bytes [FRAME_LEN];
  logic [7:0] got       [FRAME_LEN];

  always #5 clk = ~clk;

  debug_frame_tx #(.NUM_WORDS(NW), .HEADER(8'hA5)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .trig_i      (trig),
    .dbg_words_i (dbg_words),
    .tx_data_o   (tx_data),
    .tx_vld_o    (tx_vld),
    .tx_rdy_i    (tx_rdy),
    .busy_o      (busy),
    .done_o      (done),
    .frame_cnt_o (frame_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic set_words();
    dbg_words[0] = 32'h0000000C;
    dbg_words[1] = 32'h000000FF;
    dbg_words[2] = 32'h0129DACC;
  endtask

  // Caller raises trig at a negedge; this receives the frame, checks stall
  // stability, contents, and the completion cycle.
  task automatic collect(input string tag, input bit rnd, input int chg_cyc, input logic [15:0] exp_cnt);
    logic [7:0] held;
    bit         stalled;
    int         cyc;
    held    = '0;
    stalled = 1'b0;
    nrecv   = 0;
    cyc     = 0;
    while (nrecv < FRAME_LEN && cyc < 400) begin
      @(negedge clk);
      trig = 1'b0;
      cyc++;
      if (cyc == chg_cyc) dbg_words = '1;
      if (stalled) begin
        chk({tag, "_stall_vld"}, 32'(tx_vld), 32'd1);
        chk({tag, "_stall_data"}, 32'(tx_data), 32'(held));
      end
      tx_rdy = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (tx_vld && tx_rdy) begin
        got[nrecv] = tx_data;
        nrecv++;
        stalled = 1'b0;
      end else if (tx_vld) begin
        stalled = 1'b1;
        held    = tx_data;
      end
    end
    chk({tag, "_nbytes"}, 32'(nrecv), 32'(FRAME_LEN));
    for (int i = 0; i < FRAME_LEN; i++) begin
      chk({tag, "_byte"}, 32'(got[i]), 32'(exp_bytes[i]));
    end
    @(negedge clk);
    tx_rdy = 1'b0;
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_vld"}, 32'(tx_vld), 32'd0);
    chk({tag, "_cnt"}, 32'(frame_cnt), 32'(exp_cnt));
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    set_words();
    $display("frame %s: %0d bytes, frame_cnt=%0d", tag, nrecv, frame_cnt);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    trig  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    exp_bytes = '{8'hA5, 8'h03, 8'h00, 8'h00, 8'h00, 8'h0C, 8'h00, 8'h00,
                  8'h00, 8'hFF, 8'h01, 8'h29, 8'hDA, 8'hCC, 8'h6B};
    set_words();

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_data", 32'(tx_data), 32'd0);
    chk("rst_vld", 32'(tx_vld), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_cnt", 32'(frame_cnt), 32'd0);
    rst_n = 1'b1;
    $display("reset state checked");

    // Basic frame with exact cycle timing
    @(negedge clk);
    trig   = 1'b1;
    tx_rdy = 1'b1;
    for (int c = 1; c <= FRAME_LEN; c++) begin
      @(negedge clk);
      trig = 1'b0;
      chk("basic_vld", 32'(tx_vld), 32'd1);
      chk("basic_busy", 32'(busy), 32'd1);
      chk("basic_byte", 32'(tx_data), 32'(exp_bytes[c-1]));
    end
    @(negedge clk);
    chk("basic_done", 32'(done), 32'd1);
    chk("basic_idle_busy", 32'(busy), 32'd0);
    chk("basic_idle_vld", 32'(tx_vld), 32'd0);
    chk("basic_cnt", 32'(frame_cnt), 32'd1);
    @(negedge clk);
    chk("basic_done_pulse", 32'(done), 32'd0);
    tx_rdy = 1'b0;
    $display("frame basic: frame_cnt=%0d", frame_cnt);

    // Random backpressure
    @(negedge clk);
    trig = 1'b1;
    collect("bp", 1'b1, 0, 16'd2);

    // Snapshot isolation
    @(negedge clk);
    trig = 1'b1;
    collect("snap", 1'b0, 3, 16'd3);

    // Trigger while busy: two pulses collapse into one extra frame
    do_reset();
    @(negedge clk);
    trig   = 1'b1;
    tx_rdy = 1'b1;
    for (int c = 1; c <= 32; c++) begin
      @(negedge clk);
      trig = (c == 5 || c == 9);
      if (c <= 15) begin
        chk("b2b_f1_byte", 32'(tx_data), 32'(exp_bytes[c-1]));
      end else if (c == 16) begin
        chk("b2b_f1_done", 32'(done), 32'd1);
        chk("b2b_bubble_vld", 32'(tx_vld), 32'd0);
        chk("b2b_f1_cnt", 32'(frame_cnt), 32'd1);
      end else if (c <= 31) begin
        chk("b2b_f2_vld", 32'(tx_vld), 32'd1);
        chk("b2b_f2_byte", 32'(tx_data), 32'(exp_bytes[c-17]));
      end else begin
        chk("b2b_f2_done", 32'(done), 32'd1);
        chk("b2b_f2_cnt", 32'(frame_cnt), 32'd2);
      end
    end
    repeat (3) @(negedge clk);
    chk("b2b_no_third", 32'({tx_vld, busy, done}), 32'd0);
    chk("b2b_final_cnt", 32'(frame_cnt), 32'd2);
    tx_rdy = 1'b0;
    $display("frame b2b: two frames, frame_cnt=%0d", frame_cnt);

    // Reset mid-frame, with a pending trigger that must be dropped
    @(negedge clk);
    trig   = 1'b1;
    tx_rdy = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      trig = (c == 5);
      chk("midrst_byte", 32'(tx_data), 32'(exp_bytes[c-1]));
      if (c == 7) rst_n = 1'b0;
    end
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_vld", 32'(tx_vld), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_cnt", 32'(frame_cnt), 32'd0);
    chk("midrst_data", 32'(tx_data), 32'd0);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("midrst_quiet", 32'({tx_vld, busy, done}), 32'd0);
    end
    $display("reset mid-frame: outputs quiet");
    @(negedge clk);
    trig = 1'b1;
    collect("after_rst", 1'b0, 0, 16'd1);

    // Counter wrap, preloaded to the top value
    @(negedge clk);
    dut.frame_cnt_reg = 16'hFFFF;
    @(negedge clk);
    trig = 1'b1;
    collect("wrap", 1'b1, 0, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/debug_frame_tx.md
# debug_frame_tx

Debug readout transmitter for the GAT accelerator. It pairs with the in-fabric debug capture logic that exposes sticky stage flags and captured data as parallel 32-bit debug words. On a trigger it snapshots all debug words and streams them as a byte frame: header, word count, big-endian word bytes, then an XOR checksum. The frame goes out over a valid/ready byte interface toward a UART/JTAG bridge, so the host can read debug state without an ILA.

## Interface
Parameters
- NUM_WORDS, 3: number of 32-bit debug words per frame; legal range 1..63.
- HEADER, 8'hA5: first byte of every frame.

Ports
- clk, in, 1: single clock.
- rst_n, in, 1: reset, synchronous, active-low.
- trig_i, in, 1: frame request, sampled every cycle.
- dbg_words_i, in, NUM_WORDS x 32: debug words; word 0 is sent first.
- tx_data_o, out, 8: frame byte.
- tx_vld_o, out, 1: tx_data_o is valid.
- tx_rdy_i, in, 1: downstream accepts a byte when tx_vld_o and tx_rdy_i are both high.
- busy_o, out, 1: a frame is in progress (any state other than IDLE).
- done_o, out, 1: one-cycle pulse after the checksum byte is accepted.
- frame_cnt_o, out, 16: number of completed frames; wraps.

## Operation
- States and transitions:
  - IDLE -> HDR when trig_i or pending is set.
  - HDR -> CNT on handshake.
  - CNT -> DATA on handshake.
  - DATA stays in DATA for 4*NUM_WORDS handshakes, then -> CSUM.
  - CSUM -> IDLE on handshake.
- Snapshot: on the IDLE->HDR transition cycle, all of dbg_words_i is registered into a NUM_WORDS x 32 shadow. Input changes during the frame are not reflected in the frame.
- Bytes sent:
  - HDR sends HEADER.
  - CNT sends NUM_WORDS[7:0].
  - DATA sends shadow word k, bytes [31:24], [23:16], [15:8], [7:0], for k = 0..NUM_WORDS-1.
  - CSUM sends the running XOR of every byte already accepted in the frame, HEADER included.
- Checksum register:
  - Loaded with HEADER on entry to HDR.
  - XORed with each byte as it is accepted in CNT and DATA.
  - Cleared to 0 in IDLE.
- Byte index counter: 8 bits, reset to 0 on entering DATA, incremented per accepted DATA byte. The word index is index[7:2] and the byte lane is index[1:0].
- Pending flag:
  - trig_i while busy_o=1 sets pending. Multiple triggers collapse into one.
  - Pending is cleared when IDLE consumes it.
  - trig_i in the same cycle as the CSUM handshake also sets pending.
- frame_cnt_o increments by 1 in the cycle done_o is high and wraps 16'hFFFF -> 0.

## Timing
- Reset values: tx_data_o=0, tx_vld_o=0, busy_o=0, done_o=0, frame_cnt_o=0. State=IDLE, pending=0, shadow=0, checksum=0.
- Reset mid-frame: at the next clk edge with rst_n=0, all registers return to reset values. The partial frame is abandoned, no done_o is issued, and pending is dropped.
- Latency: trig_i high in IDLE at cycle t gives tx_vld_o=1 with HEADER at t+1.
- Throughput: with tx_rdy_i held high, one byte per cycle. A frame takes 3+4*NUM_WORDS cycles of tx_vld_o.
- Handshake rules:
  - While tx_vld_o=1 and tx_rdy_i=0, tx_data_o and tx_vld_o hold stable.
  - tx_vld_o never drops until the handshake completes.
  - tx_vld_o is never combinationally dependent on tx_rdy_i.
- Completion: the CSUM handshake at cycle c gives, at c+1, done_o=1, busy_o=0, tx_vld_o=0, state IDLE, frame_cnt_o+1.
- Back-to-back: if pending is set at c+1, the snapshot is taken at c+1 and HEADER is valid at c+2. There is exactly one idle bubble between frames.
- All outputs are registered.

## Test plan
All scenarios use NUM_WORDS=3 and words 0x0000000C, 0x000000FF, 0x0129DACC.
- Basic frame, tx_rdy_i=1, trig at cycle t -> bytes A5 03 00 00 00 0C 00 00 00 FF 01 29 DA CC 6B on cycles t+1..t+15; done_o=1 at t+16; frame_cnt_o=1.
- Backpressure: tx_rdy_i random at 50% -> identical 15-byte sequence; tx_data_o stable on every stalled cycle; no byte dropped or duplicated.
- Snapshot isolation: change dbg_words_i to all 0xFFFFFFFF at t+3 -> frame still ends ...01 29 DA CC 6B.
- Trigger while busy: pulse trig_i at t+5 and again at t+9 -> exactly two frames total; second HEADER at t+17; frame_cnt_o=2.
- Reset mid-frame: rst_n=0 for one cycle at t+7 -> next cycle tx_vld_o=0, busy_o=0, frame_cnt_o=0; no done_o; a new trig sends a full correct frame.
- Counter wrap: force frame_cnt_o to 16'hFFFF via 65535 frames (or fast-sim) -> after the next frame, frame_cnt_o=0.
